// File: rtl/g4_ctrl_pkg.sv
// Shared widths, entry layout and FSM state type for the G4 protocol-other
// table walk controller.
package g4_ctrl_pkg;

    localparam int unsigned INDEX_BIT_LEN    = 11;
    localparam int unsigned PACKET_BIT_LEN   = 104;
    localparam int unsigned ENTRY_DATA_WIDTH = 98;
    localparam int unsigned HOP_W            = 4;

    // Entry layout: next[97:87], ruleID[86:76], dstIP[69:38], srcIP[31:0]
    localparam int unsigned NEXT_LSB = 87;
    localparam int unsigned RULE_LSB = 76;
    localparam int unsigned DST_LSB  = 38;
    localparam int unsigned SRC_LSB  = 0;
    localparam int unsigned IP_W     = 32;

    typedef logic [INDEX_BIT_LEN-1:0]    index_t;
    typedef logic [PACKET_BIT_LEN-1:0]   tuple_t;
    typedef logic [ENTRY_DATA_WIDTH-1:0] entry_t;
    typedef logic [HOP_W-1:0]            hop_t;

    localparam index_t NULL_INDEX = '0;

    typedef enum logic [2:0] {
        StIdle,
        StLookup,
        StEval,
        StResp,
        StWrite
    } walk_state_e;

endpackage

// File: rtl/g4_other_walk_ctrl_if.sv
// Request, result and table-port bundle of the walk controller.
// slave = controller view, master = client/table view.
interface g4_other_walk_ctrl_if;
    import g4_ctrl_pkg::*;

    logic   srch_valid;
    logic   srch_ready;
    index_t srch_index;
    tuple_t srch_tuple;

    logic   upd_valid;
    logic   upd_ready;
    index_t upd_index;
    entry_t upd_data;

    logic   res_valid;
    logic   res_hit;
    index_t res_ruleID;
    hop_t   res_hops;
    logic   upd_done;

    logic   tbl_we;
    entry_t tbl_din;
    index_t tbl_index;
    tuple_t tbl_tuple;
    logic   tbl_match;
    index_t tbl_ruleID;
    index_t tbl_next_index;

    modport slave (
        input  srch_valid, srch_index, srch_tuple,
        input  upd_valid, upd_index, upd_data,
        input  tbl_match, tbl_ruleID, tbl_next_index,
        output srch_ready, upd_ready,
        output res_valid, res_hit, res_ruleID, res_hops, upd_done,
        output tbl_we, tbl_din, tbl_index, tbl_tuple
    );

    modport master (
        output srch_valid, srch_index, srch_tuple,
        output upd_valid, upd_index, upd_data,
        output tbl_match, tbl_ruleID, tbl_next_index,
        input  srch_ready, upd_ready,
        input  res_valid, res_hit, res_ruleID, res_hops, upd_done,
        input  tbl_we, tbl_din, tbl_index, tbl_tuple
    );

endinterface

// File: rtl/g4_rr_arbiter.sv
// Two-way request/grant arbiter: req[0]=search, req[1]=update. On a conflict
// the priority bit picks the winner and then flips to the loser.
module g4_rr_arbiter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic prio_q;  // 0: search preferred, 1: update preferred

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            if (req == 2'b11) begin
                gnt = prio_q ? 2'b10 : 2'b01;
            end else begin
                gnt = 2'b11;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prio_q <= 1'b0;
        end else if (en && (req == 2'b11)) begin
            prio_q <= ~prio_q;
        end
    end

endmodule

// File: rtl/g4_other_walk_ctrl.sv
// Walk controller for one G4 protocol-other chained table: arbitrates search
// and update requests onto the single table port and walks next-index chains.
module g4_other_walk_ctrl
    import g4_ctrl_pkg::*;
#(
    parameter int unsigned MAX_HOPS = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    g4_other_walk_ctrl_if.slave bus
);

    localparam hop_t MaxHops = hop_t'(MAX_HOPS);

    walk_state_e state_q;
    hop_t        hops_q;
    logic        match_prev_q;

    logic        res_valid_q;
    logic        res_hit_q;
    index_t      res_rule_q;
    hop_t        res_hops_q;
    logic        upd_done_q;

    logic        tbl_we_q;
    entry_t      tbl_din_q;
    index_t      tbl_index_q;
    tuple_t      tbl_tuple_q;

    logic [1:0]  gnt;
    logic        arb_en;
    logic        srch_fire;
    logic        upd_fire;
    logic        hit;
    logic        chain_end;

    assign arb_en = rst_n && (state_q == StIdle);

    g4_rr_arbiter u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (arb_en),
        .req   ({bus.upd_valid, bus.srch_valid}),
        .gnt   (gnt)
    );

    assign srch_fire = bus.srch_valid & gnt[0];
    assign upd_fire  = bus.upd_valid  & gnt[1];

    // The table match line may stay high from an earlier entry, so only a
    // rising edge relative to the LOOKUP-cycle sample counts as a hit.
    assign hit       = bus.tbl_match & ~match_prev_q;
    assign chain_end = (bus.tbl_next_index == NULL_INDEX) || (hops_q == MaxHops);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            hops_q       <= '0;
            match_prev_q <= 1'b0;
            res_valid_q  <= 1'b0;
            res_hit_q    <= 1'b0;
            res_rule_q   <= '0;
            res_hops_q   <= '0;
            upd_done_q   <= 1'b0;
            tbl_we_q     <= 1'b0;
            tbl_din_q    <= '0;
            tbl_index_q  <= '0;
            tbl_tuple_q  <= '0;
        end else begin
            res_valid_q <= 1'b0;
            upd_done_q  <= 1'b0;
            tbl_we_q    <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (srch_fire) begin
                        tbl_tuple_q <= bus.srch_tuple;
                        tbl_index_q <= bus.srch_index;
                        hops_q      <= '0;
                        state_q     <= StLookup;
                    end else if (upd_fire) begin
                        tbl_index_q <= bus.upd_index;
                        tbl_din_q   <= bus.upd_data;
                        tbl_we_q    <= 1'b1;
                        state_q     <= StWrite;
                    end
                end
                StLookup: begin
                    hops_q       <= hops_q + hop_t'(1);
                    match_prev_q <= bus.tbl_match;
                    state_q      <= StEval;
                end
                StEval: begin
                    if (hit) begin
                        res_valid_q <= 1'b1;
                        res_hit_q   <= 1'b1;
                        res_rule_q  <= bus.tbl_ruleID;
                        res_hops_q  <= hops_q;
                        state_q     <= StResp;
                    end else if (chain_end) begin
                        res_valid_q <= 1'b1;
                        res_hit_q   <= 1'b0;
                        res_rule_q  <= '0;
                        res_hops_q  <= hops_q;
                        state_q     <= StResp;
                    end else begin
                        tbl_index_q <= bus.tbl_next_index;
                        state_q     <= StLookup;
                    end
                end
                StResp: begin
                    state_q <= StIdle;
                end
                StWrite: begin
                    upd_done_q <= 1'b1;
                    state_q    <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.srch_ready = gnt[0];
    assign bus.upd_ready  = gnt[1];
    assign bus.res_valid  = res_valid_q;
    assign bus.res_hit    = res_hit_q;
    assign bus.res_ruleID = res_rule_q;
    assign bus.res_hops   = res_hops_q;
    assign bus.upd_done   = upd_done_q;
    assign bus.tbl_we     = tbl_we_q;
    assign bus.tbl_din    = tbl_din_q;
    assign bus.tbl_index  = tbl_index_q;
    assign bus.tbl_tuple  = tbl_tuple_q;

endmodule
